// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding IF_ID through a small {pc, instr} FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to IF_ID when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h6000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;
  state_t state;
  logic [31:0] fetch_pc, req_addr, target;
  logic [31:0] pc_mem [FIFO_DEPTH];
  logic [31:0] instr_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, next_count;
  logic empty, resp_ok, bypass, push, fifo_pop, pop, space;
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign empty = count == '0;
  assign resp_ok = state == FETCH && imem_resp && !redirect;
`ifdef FETCH_BYPASS_EN
  assign bypass = empty && resp_ok && !stall;
`else
  assign bypass = 1'b0;
`endif
  assign push = resp_ok && !bypass;
  assign fifo_pop = !empty && !stall && !redirect;
  assign pop = if_valid && !stall && !redirect;
  assign space = count < DEPTH || pop;
  assign next_count = count + (AW+1)'(push) - (AW+1)'(fifo_pop);
  assign imem_read = state != IDLE;
  assign imem_addr = req_addr;
  assign if_valid = !empty || bypass;
  assign if_pc = bypass ? req_addr : empty ? 32'h0 : pc_mem[rd_ptr];
  assign if_instr = bypass ? imem_rdata : empty ? 32'h0000_0013 : instr_mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= req_addr;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= redirect ? '0 : next_count;
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(fifo_pop);
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
      unique case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target;
            req_addr <= target;
            state <= FETCH;
          end else if (space) begin
            req_addr <= fetch_pc;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (redirect) begin
            fetch_pc <= target;
            if (imem_resp) req_addr <= target;
            else state <= DROP;
          end else if (imem_resp) begin
            fetch_pc <= req_addr + 32'd4;
            if (next_count < DEPTH) req_addr <= req_addr + 32'd4;
            else state <= IDLE;
          end
        end
        DROP: begin
          // the outstanding wrong-path response is swallowed; bus address stays put until it lands
          if (redirect) fetch_pc <= target;
          if (imem_resp) begin
            req_addr <= redirect ? target : fetch_pc;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit; the expected stream is program order
// from the last reset/redirect target, with each word given by a fixed address hash.
module tb_fetch_unit;
  localparam logic [31:0] A0 = 32'h6000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_read, imem_resp = 1'b0, redirect = 1'b0, stall = 1'b0, if_valid;
  logic [31:0] imem_addr, imem_rdata = 32'h0, redirect_pc = 32'h0, if_pc, if_instr;
  int n_tests = 0, n_fail = 0, n_pops = 0, p0;
  int mem_lat = 1, mem_wait = 0;
  bit rand_lat = 0, mem_busy = 0, prev_redir = 0, found;
  logic [31:0] lat_addr, gen_pc;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 32) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] base);
    exp_q.delete();
    gen_pc = base;
    topup();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic at_neg();
    @(negedge clk);
    topup();
  endtask

  task automatic rst_checks();
    #1;
    chk("rst_imem_read", imem_read, 0);
    chk("rst_imem_addr", imem_addr, A0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 32'h13);
  endtask

  // reset lands mid-cycle, away from any clock edge
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 0;
    stall = 0;
    redirect = 0;
    restart(A0);
    rst_checks();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
  endtask

  // memory: answers each observed request after a latency, checks the bus holds still meanwhile
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mem_busy = 0;
      imem_resp = 0;
    end else begin
      if (imem_resp) begin
        imem_resp = 0;
        mem_busy = 0;
      end
      if (mem_busy) begin
        chk("hold_read", imem_read, 1);
        chk("addr_stable", imem_addr, lat_addr);
        mem_wait--;
        if (mem_wait == 0) begin
          imem_resp = 1;
          imem_rdata = mem_word(lat_addr);
        end
      end else if (imem_read) begin
        mem_busy = 1;
        lat_addr = imem_addr;
        mem_wait = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      end
    end
    if (!imem_resp) imem_rdata = $urandom;
  end

  // monitor: every entry IF_ID accepts is popped from the scoreboard and compared
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) prev_redir = 0;
    else begin
      if (prev_redir) chk("valid_after_redirect", if_valid, 0);
      if (!if_valid) begin
        chk("idle_pc", if_pc, 0);
        chk("idle_instr", if_instr, 32'h13);
      end else if (!stall && !redirect) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: got pc %h expected no entry", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_instr", if_instr, mem_word(e));
          n_pops++;
        end
      end
      prev_redir = redirect;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 0;
    restart(A0);
    rst_checks();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    // sequential fetch with a 1-cycle memory
    at_neg; chk("c0_read", imem_read, 0);
    at_neg; chk("c1_read", imem_read, 1); chk("c1_addr", imem_addr, A0); chk("c1_valid", if_valid, 0);
    at_neg; chk("c2_resp", imem_resp, 1);
`ifdef FETCH_BYPASS_EN
    chk("c2_bypass_valid", if_valid, 1); chk("c2_bypass_instr", if_instr, mem_word(A0));
`else
    chk("c2_valid", if_valid, 0);
`endif
    at_neg; chk("c3_addr", imem_addr, A0 + 32'd4);
`ifdef FETCH_BYPASS_EN
    chk("c3_valid", if_valid, 0);
`else
    chk("c3_valid", if_valid, 1); chk("c3_pc", if_pc, A0);
`endif
    at_neg; chk("c4_resp", imem_resp, 1);
    at_neg; chk("c5_addr", imem_addr, A0 + 32'd8);
`ifndef FETCH_BYPASS_EN
    chk("c5_pc", if_pc, A0 + 32'd4);
`endif
    // stall fills the FIFO and stops fetching
    do_reset();
    stall = 1;
    repeat (10) at_neg;
    chk("stall_read", imem_read, 0);
    chk("stall_valid", if_valid, 1);
    chk("stall_pc", if_pc, A0);
    chk("stall_instr", if_instr, mem_word(A0));
    at_pos; stall = 0;
    at_neg; chk("unstall_pc0", if_pc, A0);
    at_neg; chk("unstall_pc1", if_pc, A0 + 32'd4); chk("unstall_valid1", if_valid, 1);
    repeat (6) at_neg;
    // redirect while a slow request is outstanding
    do_reset();
    mem_lat = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      at_neg;
      if (imem_read && imem_addr == A0 + 32'd8) found = 1;
    end
    chk("t3_found_req", found, 1);
    at_pos; redirect = 1; redirect_pc = 32'h6000_0100; restart(32'h6000_0100);
    at_pos; redirect = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      at_neg;
      if (imem_addr !== A0 + 32'd8) found = 1;
      else begin
        chk("t3_gap_valid", if_valid, 0);
        chk("t3_gap_read", imem_read, 1);
      end
    end
    chk("t3_left_drop", found, 1);
    chk("t3_next_addr", imem_addr, 32'h6000_0100);
    chk("t3_next_read", imem_read, 1);
    repeat (10) at_neg;
    // redirect coinciding with a response
    do_reset();
    mem_lat = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      at_neg;
      if (mem_busy && mem_wait == 1 && !imem_resp) found = 1;
    end
    chk("t4_found", found, 1);
    at_pos; redirect = 1; redirect_pc = 32'h6000_0203; restart(32'h6000_0200);
    at_neg; chk("t4_resp", imem_resp, 1);
    at_pos; redirect = 0;
    at_neg;
    chk("t4_addr", imem_addr, 32'h6000_0200);
    chk("t4_read", imem_read, 1);
    chk("t4_valid", if_valid, 0);
    repeat (8) at_neg;
    // asynchronous reset with one entry buffered and a request in flight
    do_reset();
    mem_lat = 3;
    stall = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      at_neg;
      if (if_valid) found = 1;
    end
    chk("t5_buffered", found, 1);
    chk("t5_fetching", imem_read, 1);
    do_reset();
    at_neg;
    at_neg;
    chk("t5_restart_addr", imem_addr, A0);
    chk("t5_restart_read", imem_read, 1);
    // PC wraps through 32'hFFFF_FFFC to 0
    mem_lat = 1;
    at_pos; redirect = 1; redirect_pc = 32'hFFFF_FFFA; restart(32'hFFFF_FFF8);
    at_pos; redirect = 0;
    p0 = n_pops;
    repeat (16) at_neg;
    chk("wrap_progress", n_pops - p0 >= 4, 1);
    // random stalls, redirects, latencies and occasional resets
    rand_lat = 1;
    p0 = n_pops;
    for (int c = 0; c < 3000; c++) begin
      at_pos;
      redirect = 0;
      stall = $urandom_range(0, 99) < 30;
      if (c % 1000 == 999) do_reset();
      else if ($urandom_range(0, 99) < 4) begin
        redirect = 1;
        redirect_pc = {16'h6000, 16'($urandom_range(0, 65535))};
        restart(redirect_pc & 32'hFFFF_FFFC);
      end
    end
    at_pos; redirect = 0; stall = 0;
    repeat (10) at_neg;
    chk("rand_progress", n_pops - p0 > 200, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the IF_ID pipeline register.
- Owns the fetch PC and drives the instruction-memory request/response handshake.
- Buffers returned instructions in a small FIFO of {pc, instr} pairs and presents the head entry to IF_ID with a valid flag.
- Handles back-pressure from IF_ID (stall) and control-flow redirects from EX (branch/jump), discarding any in-flight wrong-path response.

Parameters:
- RESET_PC, 32'h6000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, number of buffered {pc, instr} entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 resets immediately regardless of clk.
- imem_read  out  1  instruction-memory read request; held high until imem_resp.
- imem_addr  out  32  request address; stable while imem_read=1 and no imem_resp has arrived.
- imem_rdata  in  32  instruction word; sampled only when imem_resp=1.
- imem_resp  in  1  single-cycle response strobe for the outstanding request.
- redirect  in  1  EX-stage taken branch/jump; flushes the unit.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- stall  in  1  IF_ID hold; the head entry is not consumed.
- if_valid  out  1  head FIFO entry is valid.
- if_pc  out  32  PC of the head entry; 0 when if_valid=0.
- if_instr  out  32  instruction of the head entry; 32'h0000_0013 (NOP) when if_valid=0.

Behaviour:
- Reset values: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, FIFO empty, imem_read=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h13.
- Outputs: imem_read=1 in states FETCH and DROP; imem_addr=req_addr.
- At most one outstanding request at any time.
- pop = if_valid & ~stall & ~redirect.
- space = (count < FIFO_DEPTH) | pop.
- State IDLE:
  - redirect: flush FIFO; fetch_pc=req_addr=redirect_pc; go to FETCH.
  - else if space: req_addr=fetch_pc; go to FETCH.
- State FETCH:
  - resp & ~redirect: push {req_addr, imem_rdata}; fetch_pc=req_addr+4 (32-bit wrap, no carry out).
    - If the FIFO still has space after this push and any same-cycle pop: req_addr=req_addr+4; stay in FETCH.
    - Otherwise go to IDLE.
  - resp & redirect: drop the response; flush FIFO; req_addr=fetch_pc=redirect_pc; stay in FETCH.
  - ~resp & redirect: flush FIFO; fetch_pc=redirect_pc; req_addr is unchanged (the bus must stay stable); go to DROP.
- State DROP:
  - resp: discard imem_rdata; req_addr=fetch_pc; go to FETCH.
  - redirect with or without resp: fetch_pc=redirect_pc. If resp also arrives, req_addr=redirect_pc.
  - A redirect in DROP never produces a push.
- Priority: redirect > resp > pop.
- Flush clears all entries in the same edge; if_valid=0 the cycle after a redirect.
- Push and pop in the same cycle on a full FIFO is legal; count is unchanged.
- Latency: first imem_read=1 is on the first clock edge after rst deasserts. An instruction appears on if_valid the cycle after its imem_resp.
- Steady-state throughput is one instruction per two cycles for a 1-cycle memory, because the response is registered.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, imem_resp=1, redirect=0 and stall=0, imem_rdata and req_addr drive if_instr/if_pc combinationally with if_valid=1 in the same cycle. The entry is consumed without being written to the FIFO.
- If stall=1 in that cycle, the entry is pushed as normal.
- Undefined: no combinational path from imem_* to if_*; behaviour exactly as above.

Test Plan:
- Reset, then release; memory responds 1 cycle after each read -> imem_addr sequence 6000_0000, 6000_0004, 6000_0008; if_pc follows the same sequence, each one cycle after its imem_resp.
- Hold stall=1 from the first if_valid -> FIFO fills with 2 entries (pc 6000_0000 and 6000_0004); imem_read drops to 0; if_pc stays 6000_0000 until stall=0.
- Memory latency 3 cycles; redirect=1 to 6000_0100 one cycle after the request to 6000_0008 is issued -> imem_addr stays 6000_0008 until resp; that data is never visible; next request is 6000_0100; if_valid=0 in between.
- redirect and imem_resp in the same cycle, redirect_pc=6000_0203 -> response dropped; next imem_addr=6000_0200; FIFO empty.
- Assert rst=0 asynchronously mid-FETCH with 1 entry buffered -> imem_read=0, if_valid=0 and if_instr=32'h13 immediately, without a clock edge; fetch restarts at 6000_0000.
- Under FETCH_BYPASS_EN, empty FIFO, resp with rdata=32'h0050_0093 -> if_valid=1 and if_instr=32'h0050_0093 in the same cycle; with the macro undefined, they appear one cycle later.
